// File: rtl/apb2ahb_if.sv
// Signal bundle between an APB3 requester and an AHB-Lite completer, with the
// apb2ahb bridge sitting in the middle as APB completer and AHB manager.
interface apb2ahb_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) ();
   // APB3 side
   logic                  PSEL;
   logic                  PENABLE;
   logic [ADDR_WIDTH-1:0] PADDR;
   logic                  PWRITE;
   logic [DATA_WIDTH-1:0] PWDATA;
   logic [DATA_WIDTH-1:0] PRDATA;
   logic                  PREADY;
   logic                  PSLVERR;
   // AHB-Lite side
   logic [1:0]            HTRANS;
   logic [ADDR_WIDTH-1:0] HADDR;
   logic                  HWRITE;
   logic [2:0]            HSIZE;
   logic [2:0]            HBURST;
   logic [3:0]            HPROT;
   logic [DATA_WIDTH-1:0] HWDATA;
   logic                  HREADY;
   logic                  HRESP;
   logic [DATA_WIDTH-1:0] HRDATA;

   // The bridge: completer on APB, manager on AHB.
   modport slave (
      input  PSEL, PENABLE, PADDR, PWRITE, PWDATA, HREADY, HRESP, HRDATA,
      output PRDATA, PREADY, PSLVERR, HTRANS, HADDR, HWRITE, HSIZE, HBURST,
             HPROT, HWDATA
   );

   // The environment: APB requester plus AHB completer.
   modport master (
      output PSEL, PENABLE, PADDR, PWRITE, PWDATA, HREADY, HRESP, HRDATA,
      input  PRDATA, PREADY, PSLVERR, HTRANS, HADDR, HWRITE, HSIZE, HBURST,
             HPROT, HWDATA
   );
endinterface

// File: rtl/apb2ahb.sv
// APB3 completer that replays each APB transfer as one non-pipelined AHB-Lite
// SINGLE word transfer; minimum APB latency is two wait states.
module apb2ahb #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic     clk,
   input  logic     n_rst,
   apb2ahb_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   state_t                r_state;
   state_t                w_next;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_write;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic                  r_err;
   logic                  r_pready;
   logic                  w_setup;
   logic                  w_data_end;
   logic [1:0]            w_htrans;

   assign w_setup    = bus.PSEL & ~bus.PENABLE;
   assign w_data_end = (r_state == S_DATA) & bus.HREADY;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_setup)     w_next = S_ADDR;
         S_ADDR:  if (bus.HREADY)  w_next = S_DATA;
         S_DATA:  if (bus.HREADY)  w_next = S_DONE;
         S_DONE:                   w_next = S_IDLE;
         default:                  w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_htrans = HTRANS_IDLE;
      if (r_state == S_ADDR) w_htrans = HTRANS_NONSEQ;
   end

   // Request is frozen at the APB setup phase; access-phase changes are ignored.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_addr  <= '0;
         r_write <= 1'b0;
         r_wdata <= '0;
      end else if ((r_state == S_IDLE) && w_setup) begin
         r_addr  <= bus.PADDR;
         r_write <= bus.PWRITE;
         r_wdata <= bus.PWDATA;
      end
   end

   // Loaded on the last data-phase edge so they are live only in DONE. HREADY
   // high with HRESP high is the second ERROR cycle; read data is dropped then.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_pready <= 1'b0;
         r_err    <= 1'b0;
         r_rdata  <= '0;
      end else begin
         r_pready <= w_data_end;
         r_err    <= w_data_end & bus.HRESP;
         r_rdata  <= (w_data_end && !bus.HRESP && !r_write) ? bus.HRDATA : '0;
      end
   end

   assign bus.HTRANS  = w_htrans;
   assign bus.HADDR   = r_addr;
   assign bus.HWRITE  = r_write;
   assign bus.HWDATA  = r_wdata;
   assign bus.HSIZE   = 3'b010;
   assign bus.HBURST  = 3'b000;
   assign bus.HPROT   = 4'b0011;
   assign bus.PREADY  = r_pready;
   assign bus.PSLVERR = r_err;
   assign bus.PRDATA  = r_rdata;
endmodule

// File: tb/tb_apb2ahb.sv
// Directed and randomized transfers through apb2ahb, checked cycle by cycle
// against a transaction-level timing/data model of the bridge.
module tb_apb2ahb;
   logic clk;
   logic n_rst;
   int   checks;
   int   errors;

   apb2ahb_if bus ();

   apb2ahb u_dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         bus.PSEL    = 1'b0;
         bus.PENABLE = 1'b0;
         bus.HREADY  = 1'b1;
         bus.HRESP   = 1'b0;
         bus.HRDATA  = $urandom;
         @(negedge clk);
         chk("idle_htrans", 32'(bus.HTRANS), 32'h0);
         chk("idle_pready", 32'(bus.PREADY), 32'h0);
      end
   endtask

   // One APB transfer. The AHB completer behaviour is scheduled purely by cycle
   // number: aw address-phase stalls, dw data-phase waits, optional two-cycle
   // ERROR. Expected DONE cycle is 3 + aw + dw (+1 for ERROR).
   task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input int aw, input int dw,
                          input logic err, input logic drop, input int rst_at);
      int          lat;
      int          d;
      logic [31:0] exp_rdata;
      lat       = 3 + aw + dw + (err ? 1 : 0);
      exp_rdata = (!wr && !err) ? rd : 32'h0;

      @(posedge clk); #1;
      bus.PSEL    = 1'b1;
      bus.PENABLE = 1'b0;
      bus.PADDR   = addr;
      bus.PWRITE  = wr;
      bus.PWDATA  = wd;
      bus.HREADY  = 1'b1;
      bus.HRESP   = 1'b0;
      bus.HRDATA  = $urandom;
      @(negedge clk);
      chk("setup_htrans", 32'(bus.HTRANS), 32'h0);
      chk("setup_pready", 32'(bus.PREADY), 32'h0);

      for (int k = 1; k <= lat; k++) begin
         @(posedge clk); #1;
         bus.PENABLE = 1'b1;
         bus.PSEL    = !drop;
         bus.PADDR   = $urandom;
         bus.PWDATA  = $urandom;
         bus.PWRITE  = 1'($urandom_range(0, 1));
         bus.HRDATA  = $urandom;
         bus.HRESP   = 1'b0;
         bus.HREADY  = 1'b1;
         if (k <= aw) begin
            bus.HREADY = 1'b0;
         end else if (k > aw + 1 && k < lat) begin
            d = k - (aw + 2);
            if (d < dw) begin
               bus.HREADY = 1'b0;
            end else if (err && d == dw) begin
               bus.HREADY = 1'b0;
               bus.HRESP  = 1'b1;
            end else if (err) begin
               bus.HRESP  = 1'b1;
            end else begin
               bus.HRDATA = rd;
            end
         end
         @(negedge clk);
         if (k <= aw + 1) begin
            chk("addr_htrans", 32'(bus.HTRANS), 32'h2);
         end else begin
            chk("data_htrans", 32'(bus.HTRANS), 32'h0);
            if (k < lat) chk("data_hwdata", bus.HWDATA, wd);
         end
         chk("haddr", bus.HADDR, addr);
         chk("hwrite", 32'(bus.HWRITE), 32'(wr));
         chk("pready", 32'(bus.PREADY), 32'(k == lat));
         chk("pslverr", 32'(bus.PSLVERR), (k == lat) ? 32'(err) : 32'h0);
         chk("prdata", bus.PRDATA, (k == lat) ? exp_rdata : 32'h0);
         if (k == rst_at) begin
            #1 n_rst = 1'b0;
            #1;
            chk("rst_htrans", 32'(bus.HTRANS), 32'h0);
            chk("rst_pready", 32'(bus.PREADY), 32'h0);
            chk("rst_haddr", bus.HADDR, 32'h0);
            chk("rst_hwdata", bus.HWDATA, 32'h0);
            chk("rst_hwrite", 32'(bus.HWRITE), 32'h0);
            bus.PSEL    = 1'b0;
            bus.PENABLE = 1'b0;
            return;
         end
      end
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      n_rst       = 1'b0;
      bus.PSEL    = 1'b0;
      bus.PENABLE = 1'b0;
      bus.PADDR   = '0;
      bus.PWRITE  = 1'b0;
      bus.PWDATA  = '0;
      bus.HREADY  = 1'b1;
      bus.HRESP   = 1'b0;
      bus.HRDATA  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_htrans", 32'(bus.HTRANS), 32'h0);
      chk("reset_pready", 32'(bus.PREADY), 32'h0);
      chk("reset_pslverr", 32'(bus.PSLVERR), 32'h0);
      chk("reset_prdata", bus.PRDATA, 32'h0);
      chk("reset_haddr", bus.HADDR, 32'h0);
      chk("reset_hwrite", 32'(bus.HWRITE), 32'h0);
      chk("reset_hwdata", bus.HWDATA, 32'h0);
      chk("hsize", 32'(bus.HSIZE), 32'h2);
      chk("hburst", 32'(bus.HBURST), 32'h0);
      chk("hprot", 32'(bus.HPROT), 32'h3);
      n_rst = 1'b1;
      idle(2);

      // single write, zero wait states
      do_xfer(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0, 0, 0, 1'b0, 1'b0, 0);
      idle(1);
      // read with three data-phase waits
      do_xfer(1'b0, 32'h0000_0004, 32'h0, 32'h1234_5678, 0, 3, 1'b0, 1'b0, 0);
      idle(1);
      // ERROR response, then a clean read
      do_xfer(1'b0, 32'h0000_0020, 32'h0, 32'hCAFE_F00D, 0, 0, 1'b1, 1'b0, 0);
      do_xfer(1'b0, 32'h0000_0024, 32'h0, 32'h0BAD_CAFE, 0, 0, 1'b0, 1'b0, 0);
      idle(1);
      // address-phase stall of two cycles
      do_xfer(1'b1, 32'h4000_0000, 32'h5555_AAAA, 32'h0, 2, 0, 1'b0, 1'b0, 0);
      idle(1);
      // back-to-back write then read
      do_xfer(1'b1, 32'h0000_0100, 32'h0000_000A, 32'h0, 0, 0, 1'b0, 1'b0, 0);
      do_xfer(1'b0, 32'h0000_0104, 32'h0, 32'h7777_0104, 0, 0, 1'b0, 1'b0, 0);
      // PSEL dropped during access, transfer still completes
      do_xfer(1'b0, 32'h0000_0200, 32'h0, 32'h1357_9BDF, 1, 1, 1'b0, 1'b1, 0);
      idle(1);
      // reset while waiting in the data phase, then a fresh write
      do_xfer(1'b0, 32'h0000_0300, 32'h0, 32'hFFFF_0000, 0, 5, 1'b0, 1'b0, 3);
      repeat (2) @(negedge clk);
      chk("inrst_pready", 32'(bus.PREADY), 32'h0);
      chk("inrst_htrans", 32'(bus.HTRANS), 32'h0);
      n_rst = 1'b1;
      do_xfer(1'b1, 32'h0000_0400, 32'h0F0F_F0F0, 32'h0, 0, 0, 1'b0, 1'b0, 0);
      idle(1);

      for (int t = 0; t < 40; t++) begin
         do_xfer(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                 int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0), 0);
         idle(int'($urandom_range(0, 2)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/apb2ahb.md
Name: apb2ahb

Overview:
- APB3 completer that converts each APB transfer into one AHB-Lite SINGLE transfer, as the AHB-Lite manager. It is the reverse of the AHB-to-APB bridge.
- It lets APB-side agents (debug/config masters, DMA-lite engines) reach AHB-Lite memory and peripherals.
- Transfers are strictly non-pipelined: one APB transfer maps to exactly one AHB transfer.

Parameters:
ADDR_WIDTH, 32, PADDR/HADDR width
DATA_WIDTH, 32, PWDATA/PRDATA/HWDATA/HRDATA width; only 32 is supported

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
PSEL  input  1  APB select for this bridge
PENABLE  input  1  APB access phase
PADDR  input  ADDR_WIDTH  APB address
PWRITE  input  1  1 = write
PWDATA  input  DATA_WIDTH  APB write data
PRDATA  output  DATA_WIDTH  APB read data
PREADY  output  1  transfer complete
PSLVERR  output  1  transfer error
HTRANS  output  2  AHB transfer type; IDLE=2'b00, NONSEQ=2'b10 only
HADDR  output  ADDR_WIDTH  AHB address
HWRITE  output  1  AHB direction
HSIZE  output  3  fixed 3'b010 (word)
HBURST  output  3  fixed 3'b000 (SINGLE)
HPROT  output  4  fixed 4'b0011 (data, privileged)
HWDATA  output  DATA_WIDTH  AHB write data
HREADY  input  1  AHB bus ready
HRESP  input  1  0 = OKAY, 1 = ERROR
HRDATA  input  DATA_WIDTH  AHB read data

Behaviour:
- Reset (n_rst low, asynchronous):
  - state = IDLE.
  - PREADY, PSLVERR, HTRANS, HWRITE = 0.
  - PRDATA, HADDR, HWDATA = 0.
  - Reset mid-transfer abandons the transfer immediately; no PREADY is issued.
- Internal registers: addr_r, write_r, wdata_r, rdata_r, err_r.
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE:
  - On PSEL=1 and PENABLE=0 (APB setup), capture PADDR, PWRITE and PWDATA into addr_r, write_r and wdata_r, then go to ADDR.
  - Otherwise stay in IDLE.
  - PREADY=0.
- ADDR:
  - Drive HTRANS=NONSEQ, HADDR=addr_r, HWRITE=write_r.
  - HREADY=1: go to DATA.
  - HREADY=0: hold all address-phase outputs unchanged and stay in ADDR.
- DATA:
  - Drive HTRANS=IDLE, HWDATA=wdata_r (valid for the whole data phase).
  - HADDR and HWRITE keep their last values.
  - HREADY=1 with HRESP=0: set rdata_r=HRDATA when write_r=0 and err_r=0, then go to DONE.
  - HREADY=0 with HRESP=1: this is the first ERROR cycle; stay in DATA.
  - HREADY=1 with HRESP=1: this is the second ERROR cycle; set err_r=1, leave rdata_r unchanged, go to DONE.
  - HREADY=0 with HRESP=0: wait in DATA.
- DONE:
  - Exactly one cycle: PREADY=1 and PSLVERR=err_r.
  - PRDATA=rdata_r on reads; PRDATA=0 on writes and on errors.
  - Next state is IDLE.
- Output registration: PREADY, PSLVERR and PRDATA are registered outputs and are 0 in every state other than DONE.
- Minimum latency, with the setup phase at cycle T0:
  - NONSEQ at T1.
  - Data phase at T2.
  - PREADY=1 at T3.
  - This gives 2 APB wait states. Each AHB wait cycle adds 1.
- Back-to-back transfers: a new setup (PSEL=1, PENABLE=0) in the cycle after DONE is accepted from IDLE, so there are no dead cycles beyond IDLE.
- PSEL dropped before PREADY (APB protocol violation):
  - The AHB transfer still completes, and the DONE pulse is still issued.
  - Address, data and direction changes during the access phase are ignored; the captured values are used.
- HTRANS is never BUSY or SEQ. HSIZE, HBURST and HPROT are constants.

Test Plan:
- Single write:
  - Stimulus: APB write PADDR=0x8000_0010, PWDATA=0xDEAD_BEEF, HREADY always 1.
  - Response: HTRANS=NONSEQ with HADDR=0x8000_0010 and HWRITE=1 at T1. HWDATA=0xDEAD_BEEF at T2. PREADY=1 and PSLVERR=0 at T3 only.
- Single read with wait states:
  - Stimulus: APB read PADDR=0x0000_0004; HREADY=0 for 3 data-phase cycles, then 1 with HRDATA=0x1234_5678.
  - Response: PREADY rises exactly 1 cycle after HREADY=1, with PRDATA=0x1234_5678. Total latency is 6 cycles from setup.
- ERROR response:
  - Stimulus: read; data phase returns HRESP=1 with HREADY=0, then HRESP=1 with HREADY=1.
  - Response: PREADY=1, PSLVERR=1, PRDATA=0. The next transfer completes with PSLVERR=0.
- Address-phase stall:
  - Stimulus: HREADY=0 for 2 cycles during ADDR.
  - Response: HTRANS=NONSEQ and HADDR are held stable across all 3 cycles, then the transfer proceeds normally.
- Back-to-back:
  - Stimulus: write 0xA to 0x100, then immediately read 0x104 (setup in the cycle after PREADY).
  - Response: two NONSEQ transfers 4 cycles apart; both PREADY pulses are 1 cycle wide.
- Reset mid-transfer:
  - Stimulus: assert n_rst=0 while in DATA.
  - Response: HTRANS=0 and PREADY=0 immediately, without waiting for a clock edge. After release, the FSM is in IDLE, and a fresh write completes normally at T3.
